// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register stage with valid/ready handshake, flush and optional skid entry.
// Optional macro PIPE_STAGE_PERF_EN adds a saturating downstream-stall counter (stall_cnt).
module pipe_stage_elastic #(
  parameter int WIDTH = 64,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  logic             r_main_valid;
  logic [WIDTH-1:0] r_main_data;
  logic             w_skid_valid;
  logic             w_accept;
  logic             w_xfer;

  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_main_valid && out_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, w_skid_valid};

  generate
    if (SKID != 0) begin : g_skid
      logic             r_skid_valid;
      logic [WIDTH-1:0] r_skid_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
          r_main_data  <= '0;
          r_skid_data  <= '0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end else begin
          case ({r_skid_valid, r_main_valid})
            2'b00: begin
              if (w_accept) begin
                r_main_data  <= in_data;
                r_main_valid <= 1'b1;
              end
            end
            2'b01: begin
              if (w_accept && w_xfer) begin
                r_main_data <= in_data;
              end else if (w_accept) begin
                r_skid_data  <= in_data;
                r_skid_valid <= 1'b1;
              end else if (w_xfer) begin
                r_main_valid <= 1'b0;
              end
            end
            2'b11: begin
              // Skid drains into main so ordering stays FIFO.
              if (w_xfer) begin
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
              end
            end
            default: begin
              r_main_valid <= 1'b0;
              r_skid_valid <= 1'b0;
            end
          endcase
        end
      end

      assign in_ready     = !r_skid_valid;
      assign w_skid_valid = r_skid_valid;
    end else begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_valid <= 1'b0;
          r_main_data  <= '0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
        end else if (w_accept) begin
          r_main_data  <= in_data;
          r_main_valid <= 1'b1;
        end else if (w_xfer) begin
          r_main_valid <= 1'b0;
        end
      end

      assign in_ready     = !r_main_valid || out_ready;
      assign w_skid_valid = 1'b0;
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_skid_valid && !r_main_valid));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: one instance with skid entry, one without.
// Stall-counter checks are compiled only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_elastic;

  logic        clk;
  logic        rst_n;

  logic        i1_flush, i1_valid, o1_ready;
  logic [63:0] i1_data;
  logic        o1_in_ready, o1_valid;
  logic [63:0] o1_data;
  logic [1:0]  o1_occ;

  logic        i0_flush, i0_valid, o0_ready;
  logic [63:0] i0_data;
  logic        o0_in_ready, o0_valid;
  logic [63:0] o0_data;
  logic [1:0]  o0_occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] o1_stall, o0_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_elastic #(.WIDTH(64), .SKID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(i1_flush),
    .in_valid(i1_valid), .in_ready(o1_in_ready), .in_data(i1_data),
    .out_valid(o1_valid), .out_ready(o1_ready), .out_data(o1_data),
    .occupancy(o1_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(o1_stall)
`endif
  );

  pipe_stage_elastic #(.WIDTH(64), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(i0_flush),
    .in_valid(i0_valid), .in_ready(o0_in_ready), .in_data(i0_data),
    .out_valid(o0_valid), .out_ready(o0_ready), .out_data(o0_data),
    .occupancy(o0_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(o0_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Land 1 time unit after the rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i1_flush = 0; i1_valid = 0; i1_data = '0; o1_ready = 0;
    i0_flush = 0; i0_valid = 0; i0_data = '0; o0_ready = 0;
    #12;
    n_vec++; if (o1_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0h exp=0", o1_valid); end
    n_vec++; if (o1_data !== 64'h0) begin n_err++; $display("FAIL reset_data got=%0h exp=0", o1_data); end
    n_vec++; if (o1_occ !== 2'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", o1_occ); end
    n_vec++; if (o1_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0h exp=1", o1_in_ready); end
    n_vec++; if (o0_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_s0 got=%0h exp=1", o0_in_ready); end
    n_vec++; if (o0_occ !== 2'd0) begin n_err++; $display("FAIL reset_occ_s0 got=%0d exp=0", o0_occ); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_stream();
    o1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i1_valid = 1'b1;
      i1_data  = 64'(i + 1);
      tick();
      $display("txn stream beat %0d out=%0h", i, o1_data);
      n_vec++; if (o1_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got=%0h exp=1", i, o1_valid); end
      n_vec++; if (o1_data !== 64'(i + 1)) begin n_err++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, o1_data, i + 1); end
      n_vec++; if (o1_occ !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, o1_occ); end
    end
    i1_valid = 1'b0;
    tick();
    n_vec++; if (o1_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got=%0h exp=0", o1_valid); end
    o1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    o1_ready = 1'b0;
    i1_valid = 1'b1; i1_data = 64'hA;
    tick();
    n_vec++; if (o1_occ !== 2'd1) begin n_err++; $display("FAIL bp_occ1 got=%0d exp=1", o1_occ); end
    n_vec++; if (o1_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got=%0h exp=1", o1_in_ready); end
    i1_data = 64'hB;
    tick();
    i1_valid = 1'b0;
    n_vec++; if (o1_occ !== 2'd2) begin n_err++; $display("FAIL bp_occ2 got=%0d exp=2", o1_occ); end
    n_vec++; if (o1_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2 got=%0h exp=0", o1_in_ready); end
    n_vec++; if (o1_data !== 64'hA) begin n_err++; $display("FAIL bp_hold_a got=%0h exp=a", o1_data); end
    tick();
    n_vec++; if (o1_data !== 64'hA || o1_occ !== 2'd2) begin n_err++; $display("FAIL bp_hold2 got=%0h/%0d exp=a/2", o1_data, o1_occ); end
    o1_ready = 1'b1;
    tick();
    $display("txn bp delivered a, now %0h", o1_data);
    n_vec++; if (o1_data !== 64'hB || o1_valid !== 1'b1) begin n_err++; $display("FAIL bp_order_b got=%0h/%0h exp=b/1", o1_data, o1_valid); end
    n_vec++; if (o1_occ !== 2'd1 || o1_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_half got=%0d/%0h exp=1/1", o1_occ, o1_in_ready); end
    tick();
    n_vec++; if (o1_valid !== 1'b0 || o1_occ !== 2'd0) begin n_err++; $display("FAIL bp_empty got=%0h/%0d exp=0/0", o1_valid, o1_occ); end
    o1_ready = 1'b0;
  endtask

  task automatic test_flush();
    o1_ready = 1'b0;
    i1_valid = 1'b1; i1_data = 64'hA; tick();
    i1_data = 64'hB; tick();
    i1_flush = 1'b1; i1_data = 64'hC; o1_ready = 1'b1;
    #1;
    n_vec++; if (o1_valid !== 1'b1 || o1_data !== 64'hA) begin n_err++; $display("FAIL flush_xfer_a got=%0h/%0h exp=1/a", o1_valid, o1_data); end
    n_vec++; if (o1_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_full_ready got=%0h exp=0", o1_in_ready); end
    tick();
    i1_flush = 1'b0; i1_valid = 1'b0;
    n_vec++; if (o1_valid !== 1'b0 || o1_occ !== 2'd0) begin n_err++; $display("FAIL flush_empty got=%0h/%0d exp=0/0", o1_valid, o1_occ); end
    n_vec++; if (o1_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready_after got=%0h exp=1", o1_in_ready); end
    tick();
    n_vec++; if (o1_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_c got=%0h exp=0", o1_valid); end
    // A beat accepted into an empty stage in the flush cycle is discarded.
    i1_valid = 1'b1; i1_data = 64'hD; i1_flush = 1'b1;
    tick();
    i1_valid = 1'b0; i1_flush = 1'b0;
    n_vec++; if (o1_valid !== 1'b0 || o1_occ !== 2'd0) begin n_err++; $display("FAIL flush_prio got=%0h/%0d exp=0/0", o1_valid, o1_occ); end
    $display("txn flush done");
    o1_ready = 1'b0;
  endtask

  task automatic test_skid0_toggle();
    logic        m_valid = 1'b0;
    logic [63:0] m_data  = '0;
    logic        exp_rdy, acc, xfr;
    int          sent = 0, recv = 0, cyc = 0;
    while (recv < 8 && cyc < 40) begin
      o0_ready = (cyc % 2 == 0);
      i0_valid = (sent < 8);
      i0_data  = 64'(sent + 1);
      #1;
      exp_rdy = !m_valid || o0_ready;
      acc = i0_valid && exp_rdy;
      xfr = m_valid && o0_ready;
      n_vec++; if (o0_in_ready !== exp_rdy) begin n_err++; $display("FAIL s0_ready[%0d] got=%0h exp=%0h", cyc, o0_in_ready, exp_rdy); end
      n_vec++; if (o0_valid !== m_valid) begin n_err++; $display("FAIL s0_valid[%0d] got=%0h exp=%0h", cyc, o0_valid, m_valid); end
      if (xfr) begin
        n_vec++; if (o0_data !== 64'(recv + 1)) begin n_err++; $display("FAIL s0_data[%0d] got=%0h exp=%0h", recv, o0_data, recv + 1); end
        $display("txn s0 beat %0d out=%0h", recv, o0_data);
        recv++;
      end
      if (acc) begin
        m_valid = 1'b1; m_data = i0_data; sent++;
      end else if (xfr) begin
        m_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    n_vec++; if (recv != 8 || sent != 8) begin n_err++; $display("FAIL s0_count got=%0d/%0d exp=8/8", sent, recv); end
    i0_valid = 1'b0; o0_ready = 1'b0;
    n_vec++; if (o0_valid !== 1'b0) begin n_err++; $display("FAIL s0_final_valid got=%0h exp=0", o0_valid); end
  endtask

  task automatic test_async_reset();
    o1_ready = 1'b0;
    i1_valid = 1'b1; i1_data = 64'h11; tick();
    i1_data = 64'h22; tick();
    i1_valid = 1'b0;
    n_vec++; if (o1_occ !== 2'd2) begin n_err++; $display("FAIL ar_pre_occ got=%0d exp=2", o1_occ); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (o1_valid !== 1'b0 || o1_occ !== 2'd0) begin n_err++; $display("FAIL ar_now got=%0h/%0d exp=0/0", o1_valid, o1_occ); end
    n_vec++; if (o1_data !== 64'h0) begin n_err++; $display("FAIL ar_data got=%0h exp=0", o1_data); end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    o1_ready = 1'b1;
    tick();
    n_vec++; if (o1_valid !== 1'b0 || o1_in_ready !== 1'b1) begin n_err++; $display("FAIL ar_after got=%0h/%0h exp=0/1", o1_valid, o1_in_ready); end
    $display("txn async reset done");
    o1_ready = 1'b0;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    n_vec++; if (o1_stall !== 32'd0) begin n_err++; $display("FAIL perf_init got=%0d exp=0", o1_stall); end
    o1_ready = 1'b0;
    i1_valid = 1'b1; i1_data = 64'h5; tick();
    i1_valid = 1'b0;
    repeat (5) tick();
    n_vec++; if (o1_stall !== 32'd5) begin n_err++; $display("FAIL perf_cnt got=%0d exp=5", o1_stall); end
    i1_flush = 1'b1; o1_ready = 1'b1;
    tick();
    i1_flush = 1'b0;
    tick();
    n_vec++; if (o1_stall !== 32'd5) begin n_err++; $display("FAIL perf_flush got=%0d exp=5", o1_stall); end
    $display("txn perf stall_cnt=%0d", o1_stall);
    o1_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_skid0_toggle();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Generic, width-parametrised pipeline register stage with a valid/ready handshake and a synchronous flush. It replaces the fixed per-stage struct registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. Callers pack their stage struct into the data payload. An optional skid entry breaks the combinational ready path between stages, so back-pressure (stalls) propagates without timing loops.

Parameters:
WIDTH, 64, payload width in bits (struct width packed by the caller, excluding valid)
SKID, 1, 0 = single-entry stage with combinational in_ready; 1 = two-entry stage (main + skid) with registered in_ready

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries (branch mispredict / exception)
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  downstream payload valid
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  downstream payload
occupancy  output  2  number of held entries (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rst_n low, asynchronous): main_valid=0, skid_valid=0, main/skid data=0. Outputs: out_valid=0, out_data=0, occupancy=0. in_ready=1 (SKID=1) or 1 (SKID=0, stage empty).
- Handshakes:
  - Input accept: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - in_data is sampled only on accept.
  - Once out_valid rises, out_valid and out_data hold stable until transfer or flush.
- out_valid = main_valid and out_data = main_data, both driven directly from registers.
- Latency: 1 cycle from input accept to out_valid when the stage is empty. Throughput: 1 transfer per cycle sustained.
- SKID=0:
  - in_ready = !main_valid || out_ready (combinational).
  - On accept, main <= in_data and main_valid <= 1.
  - On transfer without accept, main_valid <= 0.
- SKID=1 states, encoded by {skid_valid, main_valid}:
  - EMPTY (00): accept -> HALF.
  - HALF (01):
    - accept && transfer -> HALF, main <= in_data.
    - accept && !transfer -> FULL, skid <= in_data.
    - transfer only -> EMPTY.
    - neither -> hold.
  - FULL (11): in_ready=0. Transfer -> HALF with main <= skid. Otherwise hold.
  - in_ready = !skid_valid, registered; there is no combinational path from out_ready to in_ready.
  - Ordering is strictly FIFO: the skid entry is never bypassed by new input.
- flush: on the next edge, main_valid=0 and skid_valid=0.
  - flush has priority over any same-cycle accept; the accepted beat is discarded.
  - A same-cycle downstream transfer still completes; downstream owns that beat.
  - in_ready is unaffected by flush during the flush cycle itself.
- occupancy = main_valid + skid_valid, a registered-equivalent value with no out_ready dependence.
- Reset mid-operation: all entries are dropped immediately. No partial output is produced after rst_n deasserts.
- Invariant: skid_valid=1 implies main_valid=1. An assertion fires if violated.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds output port stall_cnt [31:0].
  - Increments every cycle with out_valid && !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst_n; flush does not clear it.
- Not defined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- SKID=1, WIDTH=64, out_ready=1, stream in_data=0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following three cycles, out_valid continuous, occupancy=1.
- SKID=1, present 0xA then 0xB with out_ready=0 -> occupancy 1 then 2, in_ready=0 after second accept, out_data held 0xA. Raise out_ready -> 0xA then 0xB delivered in order, in_ready returns 1.
- FULL state (0xA main, 0xB skid), assert flush with in_valid=1 in_data=0xC, out_ready=1 -> 0xA transferred that cycle, next cycle out_valid=0, occupancy=0, 0xC never appears.
- SKID=0, out_ready toggling 1,0,1,0 with in_valid=1 continuous -> in_ready mirrors out_ready whenever main_valid=1, no beat lost or duplicated across 8 beats.
- Assert rst_n low asynchronously mid-cycle with occupancy=2 -> out_valid=0, occupancy=0, out_data=0 immediately, before the next clk edge.
- PIPE_STAGE_PERF_EN defined: hold out_valid=1, out_ready=0 for 5 cycles, then one flush -> stall_cnt=5, unchanged by flush.
